hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core (IF, ID, EX, MEM, WB). It shadows the decoder's register-usage fields (rs1/rs2/rd, rd_wren, is_load) through EX, MEM and WB. From that it drives every pipeline-register enable and flush, the EX-stage operand forwarding selects, and stall/flush event counters. It sits beside the ID/EX, EX/MEM and MEM/WB registers and owns no datapath.

## Interface
- CNT_W, 32: width of stall and flush counters
- i_clk  in  1  clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_id_rs1_addr  in  5  rs1 of instruction in ID (decoder rs1_addr; 0 when unused)
- i_id_rs2_addr  in  5  rs2 of instruction in ID (0 when unused)
- i_id_rd_addr  in  5  rd of instruction in ID
- i_id_rd_wren  in  1  ID instruction writes regfile
- i_id_is_load  in  1  ID instruction is a load
- i_ex_redirect  in  1  EX resolved a branch/jump mispredict this cycle
- i_mem_stall  in  1  LSU not ready; whole pipeline must freeze
- o_pc_en  out  1  PC register update enable
- o_if_id_en  out  1  IF/ID register enable
- o_if_id_flush  out  1  IF/ID register loads a bubble
- o_id_ex_flush  out  1  ID/EX register loads a bubble
- o_ex_mem_en  out  1  EX/MEM register enable
- o_mem_wb_en  out  1  MEM/WB register enable
- o_fwd_a_sel  out  2  EX operand A source: 00 ID/EX, 01 EX/MEM ALU result, 10 MEM/WB write data
- o_fwd_b_sel  out  2  same for operand B
- o_stall_cnt  out  CNT_W  load-use stall cycles since reset
- o_flush_cnt  out  CNT_W  redirect flushes since reset

## Operation
- Shadow state: three stage records (EX, MEM, WB), each holding valid, rd, rd_wren, is_load; the EX record also holds rs1 and rs2. All records are invalid after reset.
- Hazard terms:
  - load_use = EX.valid & EX.is_load & EX.rd≠0 & (EX.rd==i_id_rs1_addr | EX.rd==i_id_rs2_addr), excluding matches on address 0.
  - Forward A is 01 if MEM.valid & MEM.rd_wren & MEM.rd≠0 & MEM.rd==EX.rs1. Otherwise it is 10 if the same test passes on WB. Otherwise 00. MEM outranks WB. Forward B is identical using EX.rs2.
- Priority (highest first), with the control outputs for each case:
  1. i_reset: pc_en=0, if_id_en=0, if_id_flush=1, id_ex_flush=1, ex_mem_en=0, mem_wb_en=0, fwd=00. Records are cleared and counters are zeroed.
  2. i_mem_stall: all enables 0 and both flushes 0. Records and counters hold. Redirect and load-use are ignored this cycle and re-evaluated once the stall drops, because their inputs are held by the frozen pipeline.
  3. i_ex_redirect: pc_en=1, if_id_en=1, if_id_flush=1, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1. The EX record receives an invalid entry. o_flush_cnt increments. A simultaneous load_use is discarded because the ID instruction is being squashed.
  4. load_use: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1. The EX record receives an invalid entry. o_stall_cnt increments.
  5. Normal: all enables 1, flushes 0. The EX record receives the ID fields with valid=1.
- Record advance on any non-frozen, non-reset cycle: WB←MEM, MEM←EX, then EX is loaded as listed above.
- Forwarding selects are computed every cycle from the records. During reset they are forced to 00. During mem_stall they stay valid for the frozen EX.
- Counters wrap modulo 2^CNT_W.
- The regfile provides write-before-read, so WB-to-ID needs no forwarding from this block.

## Timing
- All control outputs are combinational from the current records and inputs, with zero latency. The pipeline registers act on the same edge.
- Records and counters update on the rising edge. A counter reflects an event on the cycle after it occurs.
- A load-use stall costs exactly 1 bubble. On the next cycle the load is in MEM, and forwarding comes from WB (10) one cycle later still.
- A redirect costs 2 bubbles: IF/ID and ID/EX.
- Reset values: o_pc_en=0, o_if_id_en=0, o_if_id_flush=1, o_id_ex_flush=1, o_ex_mem_en=0, o_mem_wb_en=0, fwd selects 00, counters 0.
- Reset deasserted: with empty records the outputs are the normal case.
- Reset asserted mid-stall or mid-redirect: reset wins in that cycle.
- i_mem_stall held for N cycles: outputs stay static and the counters do not change.

## Test plan
- Back-to-back ALU dependency (add x5 then sub x6,x5,x1) -> in sub's EX cycle fwd_a=01. For a dependent instruction two slots later -> fwd=10. No stall; counters remain 0.
- Load-use (lw x7 then add x8,x7,x7) -> exactly 1 cycle of pc_en=0, if_id_en=0, id_ex_flush=1. o_stall_cnt=1 on the following cycle. Add then gets fwd_a=fwd_b=10.
- Load followed by an independent instruction, and a load with rd=x0 followed by a use of x0 -> no stall, fwd=00.
- i_ex_redirect pulse -> if_id_flush=id_ex_flush=1 for that cycle. Redirect coinciding with load_use -> flush behaviour only, o_flush_cnt=1, o_stall_cnt=0.
- i_mem_stall held 3 cycles during a pending load-use -> all enables 0 for 3 cycles, counters unchanged. The stall then occurs on the first unfrozen cycle and o_stall_cnt increments by 1.
- i_reset asserted during a load-use stall -> reset values next edge, records invalid, counters 0. The first post-reset instruction sees fwd=00.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core: shadows register usage
// through EX/MEM/WB and drives pipeline enables, flushes, forwarding and event counters.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_id_rs1_addr,
  input  logic [4:0]       i_id_rs2_addr,
  input  logic [4:0]       i_id_rd_addr,
  input  logic             i_id_rd_wren,
  input  logic             i_id_is_load,
  input  logic             i_ex_redirect,
  input  logic             i_mem_stall,
  output logic             o_pc_en,
  output logic             o_if_id_en,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic             o_ex_mem_en,
  output logic             o_mem_wb_en,
  output logic [1:0]       o_fwd_a_sel,
  output logic [1:0]       o_fwd_b_sel,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       rd_wren;
    logic       is_load;
  } stage_rec_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rd_wren;
    logic       is_load;
  } ex_rec_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ex_rec_t          ex_q, ex_d;
  stage_rec_t       mem_q, mem_d;
  stage_rec_t       wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             load_use;

  // MEM holds the younger result, so it outranks WB for the same register.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input stage_rec_t mem_r,
                                         input stage_rec_t wb_r);
    logic [1:0] sel;
    sel = 2'b00;
    if (mem_r.valid && mem_r.rd_wren && (mem_r.rd != 5'd0) && (mem_r.rd == rs)) begin
      sel = 2'b01;
    end else if (wb_r.valid && wb_r.rd_wren && (wb_r.rd != 5'd0) && (wb_r.rd == rs)) begin
      sel = 2'b10;
    end
    return sel;
  endfunction

  always_comb begin
    load_use = ex_q.valid && ex_q.is_load && (ex_q.rd != 5'd0) &&
               ((ex_q.rd == i_id_rs1_addr) || (ex_q.rd == i_id_rs2_addr));

    o_pc_en       = 1'b1;
    o_if_id_en    = 1'b1;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    o_ex_mem_en   = 1'b1;
    o_mem_wb_en   = 1'b1;
    o_fwd_a_sel   = fwd_sel(ex_q.rs1, mem_q, wb_q);
    o_fwd_b_sel   = fwd_sel(ex_q.rs2, mem_q, wb_q);

    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (i_reset) begin
      o_pc_en       = 1'b0;
      o_if_id_en    = 1'b0;
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
      o_ex_mem_en   = 1'b0;
      o_mem_wb_en   = 1'b0;
      o_fwd_a_sel   = 2'b00;
      o_fwd_b_sel   = 2'b00;
      ex_d          = '0;
      mem_d         = '0;
      wb_d          = '0;
      stall_cnt_d   = '0;
      flush_cnt_d   = '0;
    end else if (i_mem_stall) begin
      // Frozen pipeline: hazard inputs are held, so they are re-evaluated after the stall.
      o_pc_en     = 1'b0;
      o_if_id_en  = 1'b0;
      o_ex_mem_en = 1'b0;
      o_mem_wb_en = 1'b0;
    end else begin
      wb_d  = mem_q;
      mem_d = '{valid: ex_q.valid, rd: ex_q.rd, rd_wren: ex_q.rd_wren, is_load: ex_q.is_load};
      if (i_ex_redirect) begin
        o_if_id_flush = 1'b1;
        o_id_ex_flush = 1'b1;
        ex_d          = '0;
        flush_cnt_d   = flush_cnt_q + CNT_ONE;
      end else if (load_use) begin
        o_pc_en       = 1'b0;
        o_if_id_en    = 1'b0;
        o_id_ex_flush = 1'b1;
        ex_d          = '0;
        stall_cnt_d   = stall_cnt_q + CNT_ONE;
      end else begin
        ex_d = '{valid: 1'b1, rs1: i_id_rs1_addr, rs2: i_id_rs2_addr, rd: i_id_rd_addr,
                 rd_wren: i_id_rd_wren, is_load: i_id_is_load};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

endmodule
